// File: rtl/switch_event_pkg.sv
// Shared register map and debounce-state definitions for switch_event_ctrl.
package switch_event_pkg;

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_MASK  = 2'd1;
   localparam logic [1:0] ADDR_EDGE  = 2'd2;
   localparam logic [1:0] ADDR_COUNT = 2'd3;

   typedef enum logic {
      STABLE,
      SETTLING
   } deb_state_e;

endpackage

// File: rtl/switch_debounce.sv
// One switch input: 2-flop synchronizer followed by a hold-time debouncer.
module switch_debounce
   import switch_event_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic debounced
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync1_q, sync2_q;
   deb_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        deb_q, deb_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= STABLE;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         deb_q   <= deb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      unique case (state_q)
         STABLE: begin
            // The cycle that detects the difference already counts as the first held cycle.
            if (sync2_q != deb_q) begin
               state_d = SETTLING;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = '0;
            end
         end
         SETTLING: begin
            if (sync2_q == deb_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE;
               cnt_d   = '0;
               deb_d   = sync2_q;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign debounced = deb_q;

endmodule

// File: rtl/switch_event_ctrl.sv
// Debounced switch bank with edge capture, interrupt mask and Avalon-MM registers.
// Define SWITCH_EVENT_CTRL_COUNTER_EN to add the saturating event counter at address 3.
module switch_event_ctrl
   import switch_event_pkg::*;
#(
   parameter int unsigned WIDTH           = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] deb, deb_prev_q, change;
   logic [WIDTH-1:0] mask_q, mask_d, edge_q, edge_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic [15:0]      count_rd;
   logic             unused_bus;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk      (clk),
         .reset    (reset),
         .raw      (in_port[i]),
         .debounced(deb[i])
      );
   end

   // Reads have no side effects, so the strobe is not needed.
   assign unused_bus = ^{read, writedata};

   assign change = deb ^ deb_prev_q;

   always_comb begin
      mask_d = mask_q;
      if (write && address == ADDR_MASK) begin
         mask_d = writedata[WIDTH-1:0];
      end
      // New edges are ORed in after the clear so they win over a coincident W1C.
      edge_d = edge_q;
      if (write && address == ADDR_EDGE) begin
         edge_d = edge_q & ~writedata[WIDTH-1:0];
      end
      edge_d = edge_d | change;
      irq_d  = |(edge_d & mask_d);
      case (address)
         ADDR_DATA: readdata_d = 32'(deb);
         ADDR_MASK: readdata_d = 32'(mask_q);
         ADDR_EDGE: readdata_d = 32'(edge_q);
         default:   readdata_d = 32'(count_rd);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         deb_prev_q <= '0;
         mask_q     <= '0;
         edge_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         deb_prev_q <= deb;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

`ifdef SWITCH_EVENT_CTRL_COUNTER_EN
   logic [15:0] count_q, count_d;
   logic [5:0]  n_events;
   logic [16:0] count_sum;

   always_comb begin
      n_events = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n_events = n_events + 6'(change[i]);
      end
      count_sum = {1'b0, count_q} + 17'(n_events);
      if (write && address == ADDR_COUNT) begin
         count_d = 16'(n_events);
      end else if (count_sum[16]) begin
         count_d = 16'hFFFF;
      end else begin
         count_d = count_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_rd = count_q;
`else
   assign count_rd = '0;
`endif

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Scoreboard bench for switch_event_ctrl with WIDTH=10, DEBOUNCE_CYCLES=4.
module tb_switch_event_ctrl;
   import switch_event_pkg::*;

   localparam int unsigned WIDTH = 10;
   localparam int unsigned DEB   = 4;
`ifdef SWITCH_EVENT_CTRL_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       address;
   logic             read;
   logic             write;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   typedef struct {
      string       name;
      logic [31:0] data;
      logic        irq;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic rd_seen  = 1'b0;

   always #5 clk = ~clk;

   switch_event_ctrl #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .address  (address),
      .read     (read),
      .write    (write),
      .writedata(writedata),
      .readdata (readdata),
      .in_port  (in_port),
      .irq      (irq)
   );

   // Monitor: a read accepted on an edge presents readdata/irq until the next edge.
   always @(posedge clk) rd_seen <= read;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_read: readdata=%h with no expected entry", readdata);
         end else begin
            mon_e = sb.pop_front();
            n_checks++;
            if (readdata !== mon_e.data) begin
               n_fail++;
               $display("FAIL %s: readdata=%h expected %h", mon_e.name, readdata, mon_e.data);
            end
            n_checks++;
            if (irq !== mon_e.irq) begin
               n_fail++;
               $display("FAIL %s_irq: irq=%b expected %b", mon_e.name, irq, mon_e.irq);
            end
         end
      end
   end

   function automatic logic [31:0] cnt(input int unsigned v);
      return CNT_EN ? 32'(v) : 32'd0;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input bit wr, input logic [1:0] a, input logic [31:0] wd, input bit rd,
                       input logic [31:0] ed, input logic ei, input string nm);
      address   = a;
      write     = wr;
      writedata = wd;
      read      = rd;
      if (rd) sb.push_back('{nm, ed, ei});
      cyc(1);
      write = 1'b0;
      read  = 1'b0;
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] ed, input logic ei,
                         input string nm);
      xfer(1'b0, a, 32'd0, 1'b1, ed, ei, nm);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] wd);
      xfer(1'b1, a, wd, 1'b0, 32'd0, 1'b0, "");
   endtask

   // Back-to-back reads of one address; sample k (1-based) expects hi values from k_d / k_i on.
   task automatic stream(input logic [1:0] a, input int n, input logic [31:0] d_lo,
                         input logic [31:0] d_hi, input int k_d, input logic i_lo,
                         input logic i_hi, input int k_i, input string nm);
      address = a;
      read    = 1'b1;
      for (int k = 1; k <= n; k++) begin
         sb.push_back('{$sformatf("%s_%0d", nm, k), (k >= k_d) ? d_hi : d_lo,
                        (k >= k_i) ? i_hi : i_lo});
         cyc(1);
      end
      read = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d required=0", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      read      = 1'b0;
      write     = 1'b0;
      address   = 2'd0;
      writedata = 32'd0;
      in_port   = '0;
      cyc(3);
      reset = 1'b0;

      rd_chk(ADDR_DATA, 32'd0, 1'b0, "rst_data");
      rd_chk(ADDR_MASK, 32'd0, 1'b0, "rst_mask");
      rd_chk(ADDR_EDGE, 32'd0, 1'b0, "rst_edge");
      rd_chk(ADDR_COUNT, 32'd0, 1'b0, "rst_count");

      wr(ADDR_DATA, 32'h0000_0FFF);
      rd_chk(ADDR_DATA, 32'd0, 1'b0, "data_readonly");
      wr(ADDR_MASK, 32'hFFFF_FFFF);
      rd_chk(ADDR_MASK, 32'h0000_03FF, 1'b0, "mask_width");
      wr(ADDR_MASK, 32'd0);

      // Step on bit 0: debounced rises at cycle 6, visible on readdata one cycle later.
      in_port = 10'h001;
      stream(ADDR_DATA, 7, 32'd0, 32'd1, 7, 1'b0, 1'b0, 1, "step_data");
      rd_chk(ADDR_EDGE, 32'h001, 1'b0, "edge_rise");
      rd_chk(ADDR_COUNT, cnt(1), 1'b0, "cnt_one");

      // Three-cycle glitch on bit 3 never gets through.
      in_port = 10'h009;
      cyc(3);
      in_port = 10'h001;
      cyc(10);
      rd_chk(ADDR_DATA, 32'h001, 1'b0, "glitch_data");
      rd_chk(ADDR_EDGE, 32'h001, 1'b0, "glitch_edge");
      rd_chk(ADDR_COUNT, cnt(1), 1'b0, "glitch_cnt");

      // Interrupt path.
      wr(ADDR_EDGE, 32'h001);
      rd_chk(ADDR_EDGE, 32'd0, 1'b0, "edge_w1c");
      wr(ADDR_MASK, 32'h001);
      rd_chk(ADDR_MASK, 32'h001, 1'b0, "mask_set");
      in_port = 10'h000;
      cyc(10);
      rd_chk(ADDR_EDGE, 32'h001, 1'b1, "edge_fall_irq");
      xfer(1'b1, ADDR_EDGE, 32'h001, 1'b1, 32'h001, 1'b0, "irq_clear");
      rd_chk(ADDR_EDGE, 32'd0, 1'b0, "edge_cleared");

      // Bit 5 toggles again in the exact cycle its W1C lands: the new edge wins.
      in_port = 10'h020;
      cyc(8);
      in_port = 10'h000;
      cyc(6);
      wr(ADDR_EDGE, 32'h020);
      rd_chk(ADDR_EDGE, 32'h020, 1'b0, "edge_set_wins");
      wr(ADDR_EDGE, 32'h020);
      rd_chk(ADDR_EDGE, 32'd0, 1'b0, "edge_cleared2");
      rd_chk(ADDR_COUNT, cnt(4), 1'b0, "cnt_four");

      // All ten bits change together.
      wr(ADDR_COUNT, 32'd0);
      rd_chk(ADDR_COUNT, 32'd0, 1'b0, "cnt_clear");
      in_port = 10'h3FF;
      stream(ADDR_COUNT, 8, 32'd0, cnt(10), 8, 1'b0, 1'b1, 7, "cnt_ten");
      rd_chk(ADDR_EDGE, 32'h3FF, 1'b1, "edge_all");

`ifdef SWITCH_EVENT_CTRL_COUNTER_EN
      for (int n = 0; n < 6552; n++) begin
         in_port = ~in_port;
         cyc(6);
      end
      cyc(4);
      rd_chk(ADDR_COUNT, 32'd65530, 1'b1, "cnt_near_max");
      in_port = ~in_port;
      cyc(10);
      rd_chk(ADDR_COUNT, 32'h0000_FFFF, 1'b1, "cnt_sat");
      in_port = ~in_port;
      cyc(10);
      rd_chk(ADDR_COUNT, 32'h0000_FFFF, 1'b1, "cnt_hold_sat");
`endif

      // Clear coinciding with ten events loads ten.
      in_port = ~in_port;
      cyc(6);
      wr(ADDR_COUNT, 32'd0);
      rd_chk(ADDR_COUNT, cnt(10), 1'b1, "clr_with_events");
      cyc(4);

      // Reset two cycles into SETTLING on bit 2; the pending change is dropped.
      in_port = 10'h004;
      cyc(4);
      reset   = 1'b1;
      in_port = 10'h000;
      cyc(2);
      reset = 1'b0;
      cyc(12);
      rd_chk(ADDR_DATA, 32'd0, 1'b0, "abort_data");
      rd_chk(ADDR_MASK, 32'd0, 1'b0, "abort_mask");
      rd_chk(ADDR_EDGE, 32'd0, 1'b0, "abort_edge");
      rd_chk(ADDR_COUNT, 32'd0, 1'b0, "abort_count");

      // Switch already high across reset: edge lands 2+DEB+1 cycles after release.
      reset   = 1'b1;
      in_port = 10'h002;
      cyc(2);
      reset = 1'b0;
      stream(ADDR_EDGE, 8, 32'd0, 32'h002, 8, 1'b0, 1'b0, 1, "post_reset_edge");
      rd_chk(ADDR_COUNT, cnt(1), 1'b0, "post_reset_cnt");

      cyc(3);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
